// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: issues one imem read at the PC, holds the returned word for decode, then advances the PC.
// Latency: request accept -> data registered on rvalid -> held; at least 3 cycles per instruction with zero-wait memory.
// Backpressure: stalls in S_REQ on !imem_req_ready_i, in S_WAIT on !imem_rvalid_i, in S_HOLD on !inst_ready_i.
//
// Ports:
//   clk, rst_n                       single clock, asynchronous active-low reset
//   imem_req_valid_o/_ready_i        fetch request handshake, address on imem_addr_o (== pc_o)
//   imem_rvalid_i, imem_rdata_i      read response, only sampled while waiting for it
//   inst_valid_o/inst_ready_i        hand-off of pc_o/inst_o to the decode stage
//   jump_en_i, jump_pc_i             redirect, sampled only on the inst_valid_o/inst_ready_i handshake
//   fetch_cnt_o                      64-bit retired-fetch counter, present only with
//                                    YSYX_25060170_IFU_PERF_EN defined
module ysyx_25060170_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   input  logic        jump_en_i,
   input  logic [31:0] jump_pc_i
`ifdef YSYX_25060170_IFU_PERF_EN
   ,
   output logic [63:0] fetch_cnt_o
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        hold_hs;

   // Redirect targets are forced word-aligned, so the low target bits never matter.
   logic        unused_jump_lsbs;
   assign unused_jump_lsbs = ^jump_pc_i[1:0];

   // The only cycle in which the PC may change and jump inputs are looked at.
   assign hold_hs = (state_q == S_HOLD) && inst_ready_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      case (state_q)
         S_REQ: begin
            if (imem_req_ready_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               inst_d  = imem_rdata_i;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (inst_ready_i) begin
               pc_d    = jump_en_i ? {jump_pc_i[31:2], 2'b00} : (pc_q + 32'd4);
               state_d = S_REQ;
            end
         end
         default: begin
            // Unreachable encoding: restart the fetch at the current PC.
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   // Handshake outputs are pure decodes of the state register (no input-to-output paths).
   assign imem_req_valid_o = (state_q == S_REQ);
   assign inst_valid_o     = (state_q == S_HOLD);
   assign imem_addr_o      = pc_q;
   assign pc_o             = pc_q;
   assign inst_o           = inst_q;

`ifdef YSYX_25060170_IFU_PERF_EN
   logic [63:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (hold_hs) begin
         fetch_cnt_d = fetch_cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 64'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
